// File: rtl/rat_ckpt.sv
// Register alias table: committed values, busy/tag rename state, NUM_CKPT busy/tag snapshots.
// Latency: reads are combinational (commit bypass included); state updates on the next rising edge.
// Backpressure: none, every rename/commit/save/restore/flush is accepted in the cycle it is presented.
module rat_ckpt #(
  parameter int NUM_ARCH_REGS   = 32,
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int DATA_WIDTH      = 32,
  parameter int ROB_ENTRY_WIDTH = 8,
  parameter int NUM_CKPT        = 4,
  parameter int CKPT_WIDTH      = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [REG_ADDR_WIDTH-1:0]  raddr1,
  output logic                       valid1,
  output logic [DATA_WIDTH-1:0]      rdata1,
  output logic [ROB_ENTRY_WIDTH-1:0] rob_index1_out,
  input  logic [REG_ADDR_WIDTH-1:0]  raddr2,
  output logic                       valid2,
  output logic [DATA_WIDTH-1:0]      rdata2,
  output logic [ROB_ENTRY_WIDTH-1:0] rob_index2_out,
  input  logic                       dec_we,
  input  logic [REG_ADDR_WIDTH-1:0]  waddr,
  input  logic [ROB_ENTRY_WIDTH-1:0] rob_index_in,
  input  logic                       rob_we,
  input  logic [REG_ADDR_WIDTH-1:0]  rob_waddr,
  input  logic [DATA_WIDTH-1:0]      rob_wdata,
  input  logic [ROB_ENTRY_WIDTH-1:0] rob_tag,
  input  logic                       ckpt_save,
  input  logic [CKPT_WIDTH-1:0]      ckpt_save_id,
  input  logic                       ckpt_restore,
  input  logic [CKPT_WIDTH-1:0]      ckpt_restore_id,
  input  logic                       flush_all
);

  localparam logic [NUM_ARCH_REGS-1:0] ONE = NUM_ARCH_REGS'(1);

  logic [DATA_WIDTH-1:0]      value        [NUM_ARCH_REGS];
  logic [NUM_ARCH_REGS-1:0]   busy, busy_nxt;
  logic [ROB_ENTRY_WIDTH-1:0] tag          [NUM_ARCH_REGS];
  logic [ROB_ENTRY_WIDTH-1:0] tag_nxt      [NUM_ARCH_REGS];
  logic [NUM_ARCH_REGS-1:0]   ckpt_busy     [NUM_CKPT];
  logic [NUM_ARCH_REGS-1:0]   ckpt_busy_nxt [NUM_CKPT];
  logic [ROB_ENTRY_WIDTH-1:0] ckpt_tag      [NUM_CKPT][NUM_ARCH_REGS];
  logic [ROB_ENTRY_WIDTH-1:0] ckpt_tag_nxt  [NUM_CKPT][NUM_ARCH_REGS];

  // One-hot commit/rename selects; register 0 is excluded so it never gets state.
  logic [NUM_ARCH_REGS-1:0] com_sel, ren_sel;
  assign com_sel = (rob_we && rob_waddr != '0) ? (ONE << rob_waddr) : '0;
  assign ren_sel = (dec_we && waddr != '0) ? (ONE << waddr) : '0;

  // Next busy/tag table and snapshot slots: flush > restore > {commit, rename, save}.
  always_comb begin
    busy_nxt      = busy;
    tag_nxt       = tag;
    ckpt_busy_nxt = ckpt_busy;
    ckpt_tag_nxt  = ckpt_tag;
    // Commits retire matching tags in every snapshot so a later restore cannot revive them.
    for (int s = 0; s < NUM_CKPT; s++) begin
      for (int r = 0; r < NUM_ARCH_REGS; r++) begin
        if (com_sel[r] && ckpt_tag[s][r] == rob_tag) ckpt_busy_nxt[s][r] = 1'b0;
      end
    end
    if (flush_all) begin
      busy_nxt = '0;
      for (int s = 0; s < NUM_CKPT; s++) begin
        ckpt_busy_nxt[s] = '0;
        for (int r = 0; r < NUM_ARCH_REGS; r++) ckpt_tag_nxt[s][r] = '0;
      end
    end else if (ckpt_restore) begin
      busy_nxt = ckpt_busy_nxt[ckpt_restore_id];
      for (int r = 0; r < NUM_ARCH_REGS; r++) tag_nxt[r] = ckpt_tag[ckpt_restore_id][r];
    end else begin
      for (int r = 0; r < NUM_ARCH_REGS; r++) begin
        if (com_sel[r] && tag[r] == rob_tag) busy_nxt[r] = 1'b0;
        // A rename in the same cycle is younger than the commit, so it wins.
        if (ren_sel[r]) begin
          busy_nxt[r] = 1'b1;
          tag_nxt[r]  = rob_index_in;
        end
      end
      // Snapshot captures the post-commit, post-rename table.
      if (ckpt_save) begin
        ckpt_busy_nxt[ckpt_save_id] = busy_nxt;
        for (int r = 0; r < NUM_ARCH_REGS; r++) ckpt_tag_nxt[ckpt_save_id][r] = tag_nxt[r];
      end
    end
  end

  // State registers; the committed value is written whatever the control priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
      for (int r = 0; r < NUM_ARCH_REGS; r++) begin
        value[r] <= '0;
        tag[r]   <= '0;
      end
      for (int s = 0; s < NUM_CKPT; s++) begin
        ckpt_busy[s] <= '0;
        for (int r = 0; r < NUM_ARCH_REGS; r++) ckpt_tag[s][r] <= '0;
      end
    end else begin
      busy      <= busy_nxt;
      tag       <= tag_nxt;
      ckpt_busy <= ckpt_busy_nxt;
      ckpt_tag  <= ckpt_tag_nxt;
      if (|com_sel) value[rob_waddr] <= rob_wdata;
    end
  end

  // Source 1 read: table lookup with bypass of a tag-matched commit in flight.
  always_comb begin
    valid1         = ~busy[raddr1];
    rdata1         = value[raddr1];
    rob_index1_out = tag[raddr1];
    if (rob_we && rob_waddr == raddr1 && busy[raddr1] && tag[raddr1] == rob_tag) begin
      valid1 = 1'b1;
      rdata1 = rob_wdata;
    end
  end

  // Source 2 read: identical to source 1.
  always_comb begin
    valid2         = ~busy[raddr2];
    rdata2         = value[raddr2];
    rob_index2_out = tag[raddr2];
    if (rob_we && rob_waddr == raddr2 && busy[raddr2] && tag[raddr2] == rob_tag) begin
      valid2 = 1'b1;
      rdata2 = rob_wdata;
    end
  end

endmodule
